// File: rtl/rx_frame_ctrl_if.sv
// Purpose: bit-time counter link and host register-side signals of the UART Rx frame controller.
//   btu        : bit-time-up pulse from the bit-time counter
//   btc_start  : run enable to the bit-time counter
//   btc_baud   : terminal count to the bit-time counter
//   rx_clr     : host has read rx_data (one-cycle pulse)
//   rx_data    : received byte
//   rx_rdy     : frame available
//   perr/ferr  : parity / framing error of the last frame
//   ovf        : sticky overrun flag
// The master modport is the frame controller side; the slave modport is the counter/host side.
interface rx_frame_ctrl_if #(
   parameter int unsigned BAUD_W = 18
);
   logic              btu;
   logic              btc_start;
   logic [BAUD_W-1:0] btc_baud;
   logic              rx_clr;
   logic [7:0]        rx_data;
   logic              rx_rdy;
   logic              perr;
   logic              ferr;
   logic              ovf;

   modport master (
      input  btu, rx_clr,
      output btc_start, btc_baud, rx_data, rx_rdy, perr, ferr, ovf
   );

   modport slave (
      output btu, rx_clr,
      input  btc_start, btc_baud, rx_data, rx_rdy, perr, ferr, ovf
   );
endinterface

// File: rtl/rx_frame_ctrl.sv
// Purpose: receive-side control FSM of the UART Rx engine. Detects the start bit, paces the
// external bit-time counter, deserializes 7/8 data bits plus optional parity, checks the stop bit
// and presents the frame with ready/parity/framing/overrun flags.
// Ports:
//   Clk, Rst        : clock, asynchronous active-low reset
//   rx              : synchronized serial input, idle high
//   baud_div        : clocks per bit time (>= 4)
//   eight/pen/ohel  : 8 data bits / parity enable / odd parity, latched at start of frame
//   bus (master)    : bit-time counter link and host register signals
module rx_frame_ctrl #(
   parameter int unsigned BAUD_W = 18
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              rx,
   input  logic [BAUD_W-1:0] baud_div,
   input  logic              eight,
   input  logic              pen,
   input  logic              ohel,
   rx_frame_ctrl_if.master   bus
);
   localparam int unsigned CNT_W = 4;
   localparam int unsigned SH_W  = 9;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t             state_q, state_d;
   logic               eight_q, eight_d;
   logic               pen_q, pen_d;
   logic               ohel_q, ohel_d;
   logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [SH_W-1:0]    shreg_q, shreg_d;
   logic [7:0]         rx_data_q, rx_data_d;
   logic               rx_rdy_q, rx_rdy_d;
   logic               perr_q, perr_d;
   logic               ferr_q, ferr_d;
   logic               ovf_q, ovf_d;
   logic               btc_start_c;
   logic [BAUD_W-1:0]  btc_baud_c;
   logic [CNT_W-1:0]   n_bits_c;
   logic [CNT_W-1:0]   cnt_inc_c;
   logic [7:0]         data_c;
   logic               par_c;

   // State and datapath registers
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q   <= IDLE;
         eight_q   <= 1'b0;
         pen_q     <= 1'b0;
         ohel_q    <= 1'b0;
         bit_cnt_q <= '0;
         shreg_q   <= '0;
         rx_data_q <= '0;
         rx_rdy_q  <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         eight_q   <= eight_d;
         pen_q     <= pen_d;
         ohel_q    <= ohel_d;
         bit_cnt_q <= bit_cnt_d;
         shreg_q   <= shreg_d;
         rx_data_q <= rx_data_d;
         rx_rdy_q  <= rx_rdy_d;
         perr_q    <= perr_d;
         ferr_q    <= ferr_d;
         ovf_q     <= ovf_d;
      end
   end

   // Next-state, datapath update and counter-control decode
   always_comb begin
      state_d     = state_q;
      eight_d     = eight_q;
      pen_d       = pen_q;
      ohel_d      = ohel_q;
      bit_cnt_d   = bit_cnt_q;
      shreg_d     = shreg_q;
      rx_data_d   = rx_data_q;
      rx_rdy_d    = rx_rdy_q;
      perr_d      = perr_q;
      ferr_d      = ferr_q;
      ovf_d       = ovf_q;
      btc_start_c = 1'b0;
      btc_baud_c  = baud_div;
      n_bits_c    = (eight_q ? CNT_W'(8) : CNT_W'(7)) + CNT_W'(pen_q);
      cnt_inc_c   = CNT_W'(bit_cnt_q + CNT_W'(1));
      // data bits sit at shreg[0..], parity directly after the last data bit
      data_c      = eight_q ? shreg_q[7:0] : {1'b0, shreg_q[6:0]};
      par_c       = eight_q ? shreg_q[8] : shreg_q[7];

      if (bus.rx_clr) begin
         rx_rdy_d = 1'b0;
         ovf_d    = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (!rx) begin
               state_d   = START;
               eight_d   = eight;
               pen_d     = pen;
               ohel_d    = ohel;
               bit_cnt_d = '0;
            end
         end
         START: begin
            btc_start_c = 1'b1;
            btc_baud_c  = BAUD_W'(baud_div >> 1);
            if (bus.btu) begin
               state_d = rx ? IDLE : DATA;
            end
         end
         DATA: begin
            btc_start_c = 1'b1;
            if (bus.btu) begin
               shreg_d[bit_cnt_q] = rx;
               bit_cnt_d          = cnt_inc_c;
               if (cnt_inc_c == n_bits_c) begin
                  state_d = STOP;
               end
            end
         end
         STOP: begin
            btc_start_c = 1'b1;
            if (bus.btu) begin
               state_d   = IDLE;
               rx_data_d = data_c;
               perr_d    = pen_q & ((^data_c ^ par_c) != ohel_q);
               ferr_d    = ~rx;
               rx_rdy_d  = 1'b1;
               // a same-cycle rx_clr consumes the old frame, so no overrun
               ovf_d     = (ovf_q | rx_rdy_q) & ~bus.rx_clr;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.btc_start = btc_start_c;
   assign bus.btc_baud  = btc_baud_c;
   assign bus.rx_data   = rx_data_q;
   assign bus.rx_rdy    = rx_rdy_q;
   assign bus.perr      = perr_q;
   assign bus.ferr      = ferr_q;
   assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Bench for rx_frame_ctrl: serial frame driver, bit-time counter model and a scoreboard monitor.
module tb_rx_frame_ctrl;
   localparam int unsigned BAUD_W = 18;

   typedef struct packed {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
   } exp_t;

   logic              Clk;
   logic              Rst;
   logic              rx;
   logic [BAUD_W-1:0] baud_div;
   logic              eight;
   logic              pen;
   logic              ohel;
   logic [BAUD_W-1:0] btc_cnt;
   logic              rdy_prev;
   exp_t              sb_q[$];
   int                errors;
   int                checks;

   rx_frame_ctrl_if #(.BAUD_W(BAUD_W)) bus ();

   rx_frame_ctrl #(.BAUD_W(BAUD_W)) dut (
      .Clk      (Clk),
      .Rst      (Rst),
      .rx       (rx),
      .baud_div (baud_div),
      .eight    (eight),
      .pen      (pen),
      .ohel     (ohel),
      .bus      (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Bit-time counter: pulses btu every btc_baud clocks while enabled, self-clearing on btu
   always @(posedge Clk or negedge Rst) begin
      if (!Rst || !bus.btc_start) begin
         btc_cnt <= '0;
         bus.btu <= 1'b0;
      end else if (btc_cnt >= bus.btc_baud - BAUD_W'(1)) begin
         btc_cnt <= '0;
         bus.btu <= 1'b1;
      end else begin
         btc_cnt <= btc_cnt + BAUD_W'(1);
         bus.btu <= 1'b0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every new rx_rdy rising edge is a completed frame to pop and compare
   initial begin
      exp_t e;
      rdy_prev = 1'b0;
      forever begin
         @(negedge Clk);
         if (bus.rx_rdy === 1'b1 && rdy_prev === 1'b0) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected: got frame %0h expected none at %0t", bus.rx_data, $time);
            end else begin
               e = sb_q.pop_front();
               chk("sb_data", 32'(bus.rx_data), 32'(e.data));
               chk("sb_perr", 32'(bus.perr), 32'(e.perr));
               chk("sb_ferr", 32'(bus.ferr), 32'(e.ferr));
               chk("sb_ovf", 32'(bus.ovf), 32'(0));
            end
         end
         rdy_prev = bus.rx_rdy;
      end
   end

   // Reference expectation from the bits actually placed on the line
   function automatic exp_t model(input logic [7:0] b, input logic par, input logic stop);
      exp_t e;
      int   nb;
      int   ones;
      nb   = eight ? 8 : 7;
      ones = 0;
      for (int i = 0; i < nb; i++) ones += int'(b[i]);
      e.data = eight ? b : {1'b0, b[6:0]};
      e.perr = pen && (((ones + int'(par)) % 2) != int'(ohel));
      e.ferr = !stop;
      return e;
   endfunction

   // Drives one frame on rx; a low stop bit is held only past its sample point
   task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                             input bit push, input bit clr_after, input bit clr_on_done,
                             input bit chk_btc);
      int nb;
      int bd;
      int stop_len;
      nb = eight ? 8 : 7;
      bd = int'(baud_div);
      stop_len = stop ? bd : bd / 2 + 2;
      if (push) sb_q.push_back(model(b, par, stop));
      @(negedge Clk);
      rx = 1'b0;
      for (int c = 0; c < bd; c++) begin
         if (chk_btc && c == 3) begin
            chk("btc_start_in_start", 32'(bus.btc_start), 32'(1));
            chk("btc_baud_in_start", 32'(bus.btc_baud), 32'(bd / 2));
         end
         @(negedge Clk);
      end
      for (int i = 0; i < nb; i++) begin
         rx = b[i];
         for (int c = 0; c < bd; c++) begin
            if (chk_btc && i == 0 && c == bd / 2)
               chk("btc_baud_in_data", 32'(bus.btc_baud), 32'(bd));
            @(negedge Clk);
         end
      end
      if (pen) begin
         rx = par;
         repeat (bd) @(negedge Clk);
      end
      rx = stop;
      for (int c = 0; c < stop_len; c++) begin
         if (clr_on_done) bus.rx_clr = bus.btu;
         @(negedge Clk);
      end
      bus.rx_clr = 1'b0;
      rx = 1'b1;
      repeat (bd - stop_len + 3) @(negedge Clk);
      if (clr_after) begin
         bus.rx_clr = 1'b1;
         @(negedge Clk);
         bus.rx_clr = 1'b0;
         @(negedge Clk);
      end
   endtask

   task automatic pulse_clr();
      bus.rx_clr = 1'b1;
      @(negedge Clk);
      bus.rx_clr = 1'b0;
      @(negedge Clk);
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish at %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] b;
      errors     = 0;
      checks     = 0;
      Rst        = 1'b0;
      rx         = 1'b1;
      bus.rx_clr = 1'b0;
      baud_div   = BAUD_W'(16);
      eight      = 1'b1;
      pen        = 1'b0;
      ohel       = 1'b0;
      repeat (3) @(negedge Clk);
      chk("rst_rx_rdy", 32'(bus.rx_rdy), 32'(0));
      chk("rst_rx_data", 32'(bus.rx_data), 32'(0));
      chk("rst_perr", 32'(bus.perr), 32'(0));
      chk("rst_ferr", 32'(bus.ferr), 32'(0));
      chk("rst_ovf", 32'(bus.ovf), 32'(0));
      chk("rst_btc_start", 32'(bus.btc_start), 32'(0));
      Rst = 1'b1;
      repeat (3) @(negedge Clk);

      // 8N1 frame with counter-control checks
      send_frame(8'hA5, 1'b0, 1'b1, 1, 1, 0, 1);

      // parity error / no error, even then odd sense
      pen = 1'b1;
      send_frame(8'h3C, 1'b1, 1'b1, 1, 1, 0, 0);
      send_frame(8'h3C, 1'b0, 1'b1, 1, 1, 0, 0);
      ohel = 1'b1;
      send_frame(8'h01, 1'b0, 1'b1, 1, 1, 0, 0);

      // 7 data bits, framing error
      eight = 1'b0;
      pen   = 1'b0;
      ohel  = 1'b0;
      send_frame(8'h7F, 1'b0, 1'b0, 1, 1, 0, 0);

      // false start: 5-clock glitch
      eight = 1'b1;
      @(negedge Clk);
      rx = 1'b0;
      repeat (3) @(negedge Clk);
      chk("false_start_btc_start", 32'(bus.btc_start), 32'(1));
      chk("false_start_btc_baud", 32'(bus.btc_baud), 32'(8));
      repeat (2) @(negedge Clk);
      rx = 1'b1;
      repeat (20) @(negedge Clk);
      chk("false_start_btc_drop", 32'(bus.btc_start), 32'(0));
      chk("false_start_no_rdy", 32'(bus.rx_rdy), 32'(0));

      // overrun, clear, and clear coinciding with completion
      send_frame(8'h11, 1'b0, 1'b1, 1, 0, 0, 0);
      send_frame(8'h22, 1'b0, 1'b1, 0, 0, 0, 0);
      chk("ovf_data", 32'(bus.rx_data), 32'(8'h22));
      chk("ovf_set", 32'(bus.ovf), 32'(1));
      chk("ovf_rdy", 32'(bus.rx_rdy), 32'(1));
      pulse_clr();
      chk("clr_rdy", 32'(bus.rx_rdy), 32'(0));
      chk("clr_ovf", 32'(bus.ovf), 32'(0));
      send_frame(8'h33, 1'b0, 1'b1, 1, 0, 0, 0);
      send_frame(8'h44, 1'b0, 1'b1, 0, 0, 1, 0);
      chk("clr_on_done_data", 32'(bus.rx_data), 32'(8'h44));
      chk("clr_on_done_rdy", 32'(bus.rx_rdy), 32'(1));
      chk("clr_on_done_ovf", 32'(bus.ovf), 32'(0));
      pulse_clr();

      // reset in the middle of data bit 3, then a clean frame
      send_frame(8'h66, 1'b0, 1'b1, 1, 0, 0, 0);
      b = 8'h5A;
      @(negedge Clk);
      rx = 1'b0;
      repeat (16) @(negedge Clk);
      for (int i = 0; i < 4; i++) begin
         rx = b[i];
         repeat ((i == 3) ? 8 : 16) @(negedge Clk);
      end
      Rst = 1'b0;
      repeat (2) @(negedge Clk);
      chk("midrst_rx_rdy", 32'(bus.rx_rdy), 32'(0));
      chk("midrst_rx_data", 32'(bus.rx_data), 32'(0));
      chk("midrst_flags", 32'({bus.perr, bus.ferr, bus.ovf}), 32'(0));
      chk("midrst_btc_start", 32'(bus.btc_start), 32'(0));
      rx  = 1'b1;
      Rst = 1'b1;
      repeat (40) @(negedge Clk);
      send_frame(8'h5A, 1'b0, 1'b1, 1, 1, 0, 0);

      // randomized frames
      for (int n = 0; n < 20; n++) begin
         baud_div = BAUD_W'($urandom_range(24, 6));
         eight    = 1'($urandom_range(1, 0));
         pen      = 1'($urandom_range(1, 0));
         ohel     = 1'($urandom_range(1, 0));
         b        = 8'($urandom);
         send_frame(b, 1'($urandom_range(1, 0)), ($urandom_range(3, 0) != 0), 1, 1, 0, 0);
      end

      repeat (10) @(negedge Clk);
      chk("sb_drained", 32'(sb_q.size()), 32'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
